// File: rtl/ivlbc_pkg.sv
// Shared widths, FSM encoding and defaults for the IVLBC feeder slice.
package ivlbc_pkg;

    localparam int unsigned BLOCK_W         = 64;
    localparam int unsigned KEY_W           = 80;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 40;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [KEY_W-1:0]   key_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

endpackage

// File: rtl/ivlbc_fifo.sv
// Synchronous block FIFO with a first-word-fall-through head and full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module ivlbc_fifo
    import ivlbc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  block_t data_i,
    input  logic   pop_i,
    output block_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    block_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ivlbc_feeder.sv
// Sequencer around the IVLBC round core: buffered plaintext in, one block at a time through the core, ciphertext out.
// Defining IVLBC_TIMEOUT_EN adds a RUN-phase watchdog with a sticky err flag.
module ivlbc_feeder
    import ivlbc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
`ifdef IVLBC_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLOCK_W-1:0]   in_data,
    input  logic                 key_we,
    input  logic [KEY_W-1:0]     key_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLOCK_W-1:0]   out_data,
    output logic                 busy,
    output logic                 err,
    output logic [BLOCK_W-1:0]   core_state,
    output logic [KEY_W-1:0]     core_keys,
    output logic                 core_start,
    input  logic                 core_end,
    input  logic [BLOCK_W-1:0]   core_result
);

    state_e state_q;
    key_t   key_q;
    block_t core_state_q;
    block_t out_data_q;
    block_t fifo_head;
    logic   core_start_q;
    logic   out_valid_q;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_pop;
    logic   launch;
`ifdef IVLBC_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             err_q;
`endif

    // The head leaves the FIFO on the LOAD edge, after it has been latched into core_state.
    assign fifo_pop = (state_q == ST_LOAD);
    // Only start a block when its result will find the output register free.
    assign launch   = !fifo_empty && (!out_valid_q || out_ready);

    ivlbc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .push_i  (in_valid),
        .data_i  (in_data),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            core_state_q <= '0;
            core_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
`ifdef IVLBC_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            if (key_we) begin
                key_q <= key_in;
            end
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        core_state_q <= fifo_head;
                        state_q      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    core_start_q <= 1'b1;
`ifdef IVLBC_TIMEOUT_EN
                    tmo_cnt_q    <= '0;
`endif
                    state_q      <= ST_RUN;
                end
                ST_RUN: begin
                    if (core_end) begin
                        out_data_q   <= core_result;
                        out_valid_q  <= 1'b1;
                        core_start_q <= 1'b0;
                        state_q      <= ST_CAPTURE;
                    end
`ifdef IVLBC_TIMEOUT_EN
                    // Watchdog expiry drops the block and leaves the output side alone.
                    else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_q        <= 1'b1;
                        core_start_q <= 1'b0;
                        state_q      <= ST_CAPTURE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
`endif
                end
                ST_CAPTURE: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = !fifo_full;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign core_state = core_state_q;
    assign core_keys  = key_q;
    assign core_start = core_start_q;
`ifdef IVLBC_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_ivlbc_feeder.sv
// Self-checking bench for ivlbc_feeder with a behavioural mock of the round core and an in-order scoreboard.
module tb_ivlbc_feeder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 40;
    localparam int          NBLK  = 40;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        key_we = 1'b0;
    logic [79:0] key_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        busy;
    logic        err;
    logic [63:0] core_state;
    logic [79:0] core_keys;
    logic        core_start;
    logic        core_end;
    logic [63:0] core_result;

    ivlbc_feeder #(.DEPTH(DEPTH)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .key_we      (key_we),
        .key_in      (key_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .err         (err),
        .core_state  (core_state),
        .core_keys   (core_keys),
        .core_start  (core_start),
        .core_end    (core_end),
        .core_result (core_result)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Stand-in cipher: any fixed mix of plaintext and key, with f(0,0) = 64'hDEADBEEF01234567.
    function automatic logic [63:0] cfn(input logic [63:0] pt, input logic [79:0] k);
        return pt ^ k[63:0] ^ {k[79:64], 48'h0} ^ 64'hDEADBEEF01234567;
    endfunction

    // Mock core: samples state/key while encrypt_start is low, ends after lat RUN cycles (lat 0 = never).
    int          lat = 28;
    int          run_seen = 0;
    logic        mock_end = 1'b0;
    logic        late_end = 1'b0;
    logic [63:0] s_pt = '0;
    logic [79:0] s_key = '0;

    always @(posedge sys_clk) begin
        if (!core_start) begin
            run_seen <= 0;
            mock_end <= 1'b0;
            s_pt     <= core_state;
            s_key    <= core_keys;
        end else begin
            run_seen <= run_seen + 1;
            mock_end <= (lat >= 2) && (run_seen == lat - 2);
        end
    end

    assign core_end    = mock_end | late_end;
    assign core_result = cfn(s_pt, s_key);

    // Reference model: key register, expected ciphertext queue, output-protocol rules.
    logic        mon_en = 1'b0;
    logic [79:0] m_key = '0;
    logic [63:0] exp_q[$];
    int          n_out = 0;
    int          low_cnt = 100;
    logic        prev_ov = 1'b0, prev_or = 1'b0, prev_end = 1'b0, prev_cs = 1'b0, prev_rst = 1'b1;
    logic [63:0] prev_od = '0;

    always @(negedge sys_clk) begin
        if (mon_en) begin
            check("core_keys", 128'(core_keys), 128'(m_key));
            if (prev_ov && !prev_or && !prev_rst) begin
                check("hold_valid", 128'(out_valid), 128'(1));
                check("hold_data", 128'(out_data), 128'(prev_od));
            end
            if (out_valid && !prev_ov && !prev_rst) begin
                check("valid_after_end", 128'(prev_end), 128'(1));
                check("capture_start_low", 128'(core_start), 128'(0));
            end
            if (core_start && !prev_cs) begin
                check("start_low_gap", 128'(low_cnt >= 2), 128'(1));
            end
            if (sys_rst) begin
                exp_q.delete();
                m_key = '0;
            end else begin
                if (key_we) m_key = key_in;
                if (in_valid && in_ready) exp_q.push_back(cfn(in_data, m_key));
                if (out_valid && out_ready) begin
                    n_out++;
                    check("sb_has_entry", 128'(exp_q.size() > 0), 128'(1));
                    if (exp_q.size() > 0) check("out_data", 128'(out_data), 128'(exp_q.pop_front()));
                end
            end
        end
        low_cnt  = core_start ? 0 : low_cnt + 1;
        prev_ov  = out_valid;
        prev_or  = out_ready;
        prev_end = core_end;
        prev_cs  = core_start;
        prev_rst = sys_rst;
        prev_od  = out_data;
    end

    task automatic push_blk(input logic [63:0] d);
        bit done = 1'b0;
        @(posedge sys_clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge sys_clk);
            done = in_ready;
            @(posedge sys_clk); #1;
        end
        in_valid = 1'b0;
        check("push_accept", 128'(done), 128'(1));
    endtask

    task automatic offer(input int ncyc, output int acc);
        bit fire;
        acc = 0;
        @(posedge sys_clk); #1;
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        repeat (ncyc) begin
            @(negedge sys_clk);
            fire = in_ready;
            if (fire) acc++;
            @(posedge sys_clk); #1;
            if (fire) in_data = {$urandom, $urandom};
        end
        in_valid = 1'b0;
    endtask

    task automatic write_key(input logic [79:0] k);
        @(posedge sys_clk); #1;
        key_we = 1'b1;
        key_in = k;
        @(posedge sys_clk); #1;
        key_we = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 300 && !out_valid; i++) @(negedge sys_clk);
        check(tag, 128'(out_valid), 128'(1));
    endtask

    task automatic drain();
        bit done = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge sys_clk);
            done = (exp_q.size() == 0) && !busy && !out_valid;
        end
        check("drain", 128'(done), 128'(1));
    endtask

    initial begin
        int  n_run;
        int  acc;
        int  out0;
        int  sent;
        bit  fire;

        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_core_start", 128'(core_start), 128'(0));
        check("rst_core_state", 128'(core_state), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_key", 128'(core_keys), 128'(0));
        mon_en = 1'b1;

        // Single block with a 28-cycle core.
        write_key(80'h0);
        lat = 28;
        push_blk(64'h0);
        for (int i = 0; i < 20 && !busy; i++) @(negedge sys_clk);
        check("load_busy", 128'(busy), 128'(1));
        check("load_core_state", 128'(core_state), 128'(0));
        check("load_core_start", 128'(core_start), 128'(0));
        n_run = 0;
        for (int i = 0; i < 200 && !out_valid; i++) begin
            @(negedge sys_clk);
            if (core_start) n_run++;
        end
        check("run_cycles", 128'(n_run), 128'(28));
        check("single_valid", 128'(out_valid), 128'(1));
        check("single_data", 128'(out_data), 128'(64'hDEADBEEF01234567));
        drain();

        // Back-pressure: three blocks, consumer stalled.
        out_ready = 1'b0;
        lat = 6;
        for (int i = 0; i < 3; i++) push_blk({$urandom, $urandom});
        wait_valid("bp_valid");
        repeat (20) @(negedge sys_clk);
        check("bp_idle", 128'(busy), 128'(0));
        check("bp_held", 128'(out_valid), 128'(1));
        check("bp_first", 128'(out_data), 128'(exp_q[0]));
        offer(8, acc);
        check("bp_fifo_space", 128'(acc), 128'(DEPTH - 2));
        @(negedge sys_clk);
        check("bp_full_ready", 128'(in_ready), 128'(0));
        out0 = n_out;
        drain();
        check("bp_out_count", 128'(n_out - out0), 128'(5));

        // Full FIFO while the output is stalled.
        out_ready = 1'b0;
        out0 = n_out;
        push_blk({$urandom, $urandom});
        wait_valid("full_valid");
        offer(DEPTH + 3, acc);
        check("full_accepts", 128'(acc), 128'(DEPTH));
        @(negedge sys_clk);
        check("full_ready_low", 128'(in_ready), 128'(0));
        drain();
        check("full_out_count", 128'(n_out - out0), 128'(DEPTH + 1));

        // Key change while a block is running.
        out_ready = 1'b1;
        lat = 20;
        push_blk({$urandom, $urandom});
        for (int i = 0; i < 20 && !core_start; i++) @(negedge sys_clk);
        check("key_run_start", 128'(core_start), 128'(1));
        repeat (4) @(negedge sys_clk);
        write_key({80{1'b1}});
        @(negedge sys_clk);
        check("key_midrun", 128'(core_keys), 128'({80{1'b1}}));
        check("key_still_run", 128'(core_start), 128'(1));
        push_blk({$urandom, $urandom});
        drain();

        // Random traffic with random core latency and consumer stalls.
        write_key({16'($urandom), $urandom, $urandom});
        sent = 0;
        for (int c = 0; c < 6000 && (sent < NBLK || exp_q.size() != 0 || busy || out_valid); c++) begin
            @(negedge sys_clk);
            fire = in_valid && in_ready;
            @(posedge sys_clk); #1;
            if (fire) sent++;
            if (!in_valid || fire) begin
                if (sent < NBLK && $urandom_range(0, 2) != 0) begin
                    in_valid = 1'b1;
                    in_data  = {$urandom, $urandom};
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!core_start) lat = 2 + int'($urandom_range(0, 8));
        end
        check("rand_sent", 128'(sent), 128'(NBLK));
        drain();

        // Reset in RUN cycle 10, then a stray core_end.
        lat = 28;
        push_blk({$urandom, $urandom});
        for (int i = 0; i < 20 && !core_start; i++) @(negedge sys_clk);
        repeat (8) @(negedge sys_clk);
        check("rst_mid_running", 128'(core_start), 128'(1));
        @(posedge sys_clk); #1 sys_rst = 1'b1;
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        check("midrst_core_start", 128'(core_start), 128'(0));
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_busy", 128'(busy), 128'(0));
        late_end = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 late_end = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("late_end_busy", 128'(busy), 128'(0));
        check("late_end_valid", 128'(out_valid), 128'(0));

`ifdef IVLBC_TIMEOUT_EN
        // Core never finishes: watchdog drops the block, then a normal block follows.
        lat = 0;
        push_blk({$urandom, $urandom});
        n_run = 0;
        for (int i = 0; i < 300 && !err; i++) begin
            @(negedge sys_clk);
            if (core_start) n_run++;
        end
        check("tmo_err", 128'(err), 128'(1));
        check("tmo_run_cycles", 128'(n_run), 128'(TMO));
        check("tmo_out_valid", 128'(out_valid), 128'(0));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        lat = 5;
        push_blk({$urandom, $urandom});
        drain();
        check("tmo_err_sticky", 128'(err), 128'(1));
`else
        check("err_tied_low", 128'(err), 128'(0));
        check("tmo_unused", 128'(TMO), 128'(40));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
